// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg
// Shared types for the host-side USB transaction controller:
//   pid_e        - 4-bit PID nibbles used on the wire
//   txn_status_e - per-request completion status reported to the requester
//   txn_state_e  - sequencer states
// Also provides classify_handshake(), which maps a received handshake byte to
// the status it implies.
// ---------------------------------------------------------------------------
package usb_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_e;

  typedef enum logic [2:0] {
    ST_NONE    = 3'd0,
    ST_ACK     = 3'd1,
    ST_NAK     = 3'd2,
    ST_STALL   = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_ERROR   = 3'd5
  } txn_status_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GAP,
    S_SEND_PID,
    S_SEND_B0,
    S_SEND_B1,
    S_WAIT_TXDONE,
    S_WAIT_RESP,
    S_WAIT_EOP,
    S_RETRY,
    S_REPORT
  } txn_state_e;

  // A handshake byte carries its PID in the low nibble and the one's
  // complement of it in the high nibble; a broken check nibble or any
  // non-handshake PID is a protocol error.
  function automatic txn_status_e classify_handshake(input logic [7:0] b);
    txn_status_e s;
    s = ST_ERROR;
    if (b[7:4] == ~b[3:0]) begin
      case (b[3:0])
        PID_ACK:   s = ST_ACK;
        PID_NAK:   s = ST_NAK;
        PID_STALL: s = ST_STALL;
        default:   s = ST_ERROR;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/usb_txn_timer.sv
// ---------------------------------------------------------------------------
// usb_txn_timer
// Clearable saturating up-counter with a terminal-count flag. One instance is
// shared between the inter-packet gap and the response timeout.
// Ports:
//   clk, nRST  clock, async active-low reset
//   i_clear    reset count to zero (wins over i_en)
//   i_en       count up by one this cycle
//   i_limit    terminal-count value
//   o_tc       count currently equals i_limit
// ---------------------------------------------------------------------------
module usb_txn_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  // Saturate at all-ones so a stalled wait can never wrap back to zero.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_tc = (r_count == i_limit);

endmodule

// File: rtl/usb_txn_controller.sv
// ---------------------------------------------------------------------------
// usb_txn_controller
// Host-side transaction sequencer in front of the transceiver byte interface.
// Sends {~pid,pid}, body[7:0], body[15:8]; waits for a one-byte handshake;
// retries on NAK, error or timeout; reports one status per request.
// Ports:
//   clk, nRST                       clock, async active-low reset
//   i_req_valid/o_req_ready         request handshake (accept on valid&&ready)
//   i_req_pid, i_req_body           request contents, captured on accept
//   o_xcvr_tx_data/o_xcvr_tx_valid  byte to transceiver, held until i_xcvr_tx_ack
//   i_xcvr_tx_ack, i_xcvr_tx_done   byte latched / packet on the wire
//   i_xcvr_rx_*                     received byte, end of packet, receive error
//   o_done, o_status, o_retries_used  completion pulse and held result
// ---------------------------------------------------------------------------
module usb_txn_controller
  import usb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IPG_CYCLES     = 64,
  parameter int MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_pid,
  input  logic [15:0] i_req_body,
  output logic [7:0]  o_xcvr_tx_data,
  output logic        o_xcvr_tx_valid,
  input  logic        i_xcvr_tx_ack,
  input  logic        i_xcvr_tx_done,
  input  logic [7:0]  i_xcvr_rx_data,
  input  logic        i_xcvr_rx_valid,
  input  logic        i_xcvr_rx_eop,
  input  logic        i_xcvr_rx_error,
  output logic        o_done,
  output logic [2:0]  o_status,
  output logic [1:0]  o_retries_used
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES > IPG_CYCLES ? TIMEOUT_CYCLES : IPG_CYCLES);
  localparam logic [TIMER_W-1:0] TO_LIMIT  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] IPG_LIMIT = TIMER_W'(IPG_CYCLES - 1);
  localparam logic [1:0]         RETRY_MAX = 2'(MAX_RETRY);

  txn_state_e  r_state, w_state_nxt;
  txn_status_e r_pend, w_pend_nxt;
  txn_status_e w_cls_live, w_cls_held;
  logic [3:0]  r_pid, w_pid_nxt;
  logic [15:0] r_body, w_body_nxt;
  logic [7:0]  r_rx_byte, w_rx_byte_nxt;
  logic [1:0]  r_retry_cnt, w_retry_cnt_nxt;
  logic [7:0]  r_tx_data, w_tx_data_nxt;
  logic        r_tx_valid, w_tx_valid_nxt;
  logic        r_req_ready, w_req_ready_nxt;
  logic        r_done, w_done_nxt;
  logic [2:0]  r_status, w_status_nxt;
  logic [1:0]  r_retries_used, w_retries_nxt;
  logic        w_tmr_clear, w_tmr_en, w_tmr_tc;
  logic [TIMER_W-1:0] w_tmr_limit;

  usb_txn_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk     (clk),
    .nRST    (nRST),
    .i_clear (w_tmr_clear),
    .i_en    (w_tmr_en),
    .i_limit (w_tmr_limit),
    .o_tc    (w_tmr_tc)
  );

  // Live byte covers valid+eop in the same cycle; held byte covers a
  // separate eop in WAIT_EOP.
  assign w_cls_live = classify_handshake(i_xcvr_rx_data);
  assign w_cls_held = classify_handshake(r_rx_byte);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_pend         <= ST_NONE;
      r_pid          <= '0;
      r_body         <= '0;
      r_rx_byte      <= '0;
      r_retry_cnt    <= '0;
      r_tx_data      <= '0;
      r_tx_valid     <= 1'b0;
      r_req_ready    <= 1'b1;
      r_done         <= 1'b0;
      r_status       <= ST_NONE;
      r_retries_used <= '0;
    end else begin
      r_pend         <= w_pend_nxt;
      r_pid          <= w_pid_nxt;
      r_body         <= w_body_nxt;
      r_rx_byte      <= w_rx_byte_nxt;
      r_retry_cnt    <= w_retry_cnt_nxt;
      r_tx_data      <= w_tx_data_nxt;
      r_tx_valid     <= w_tx_valid_nxt;
      r_req_ready    <= w_req_ready_nxt;
      r_done         <= w_done_nxt;
      r_status       <= w_status_nxt;
      r_retries_used <= w_retries_nxt;
    end
  end

  // Next-state and next-output logic; all outputs are registered from here.
  always_comb begin
    w_state_nxt     = r_state;
    w_pend_nxt      = r_pend;
    w_pid_nxt       = r_pid;
    w_body_nxt      = r_body;
    w_rx_byte_nxt   = r_rx_byte;
    w_retry_cnt_nxt = r_retry_cnt;
    w_tx_data_nxt   = r_tx_data;
    w_tx_valid_nxt  = r_tx_valid;
    w_req_ready_nxt = r_req_ready;
    w_done_nxt      = 1'b0;
    w_status_nxt    = r_status;
    w_retries_nxt   = r_retries_used;
    w_tmr_clear     = 1'b0;
    w_tmr_en        = 1'b0;
    w_tmr_limit     = TO_LIMIT;

    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_pid_nxt       = i_req_pid;
          w_body_nxt      = i_req_body;
          w_req_ready_nxt = 1'b0;
          w_tmr_clear     = 1'b1;
          w_state_nxt     = S_GAP;
        end
      end
      S_GAP: begin
        w_tmr_en    = 1'b1;
        w_tmr_limit = IPG_LIMIT;
        if (w_tmr_tc) begin
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = {~r_pid, r_pid};
          w_state_nxt    = S_SEND_PID;
        end
      end
      S_SEND_PID: begin
        if (i_xcvr_tx_ack) begin
          w_tx_data_nxt = r_body[7:0];
          w_state_nxt   = S_SEND_B0;
        end
      end
      S_SEND_B0: begin
        if (i_xcvr_tx_ack) begin
          w_tx_data_nxt = r_body[15:8];
          w_state_nxt   = S_SEND_B1;
        end
      end
      S_SEND_B1: begin
        if (i_xcvr_tx_ack) begin
          w_tx_valid_nxt = 1'b0;
          w_state_nxt    = S_WAIT_TXDONE;
        end
      end
      S_WAIT_TXDONE: begin
        if (i_xcvr_tx_done) begin
          w_tmr_clear = 1'b1;
          w_state_nxt = S_WAIT_RESP;
        end
      end
      // Priority: error, then a byte (beats a same-cycle timeout), then a
      // bare eop, then timeout.
      S_WAIT_RESP: begin
        w_tmr_en = 1'b1;
        if (i_xcvr_rx_error) begin
          w_pend_nxt  = ST_ERROR;
          w_state_nxt = S_RETRY;
        end else if (i_xcvr_rx_valid) begin
          w_rx_byte_nxt = i_xcvr_rx_data;
          if (i_xcvr_rx_eop) begin
            w_pend_nxt  = w_cls_live;
            w_state_nxt = (w_cls_live == ST_ACK || w_cls_live == ST_STALL) ? S_REPORT : S_RETRY;
          end else begin
            w_state_nxt = S_WAIT_EOP;
          end
        end else if (i_xcvr_rx_eop) begin
          w_pend_nxt  = ST_ERROR;
          w_state_nxt = S_RETRY;
        end else if (w_tmr_tc) begin
          w_pend_nxt  = ST_TIMEOUT;
          w_state_nxt = S_RETRY;
        end
      end
      S_WAIT_EOP: begin
        w_tmr_en = 1'b1;
        if (i_xcvr_rx_error || i_xcvr_rx_valid) begin
          w_pend_nxt  = ST_ERROR;
          w_state_nxt = S_RETRY;
        end else if (i_xcvr_rx_eop) begin
          w_pend_nxt  = w_cls_held;
          w_state_nxt = (w_cls_held == ST_ACK || w_cls_held == ST_STALL) ? S_REPORT : S_RETRY;
        end else if (w_tmr_tc) begin
          w_pend_nxt  = ST_TIMEOUT;
          w_state_nxt = S_RETRY;
        end
      end
      S_RETRY: begin
        if (r_retry_cnt < RETRY_MAX) begin
          w_retry_cnt_nxt = r_retry_cnt + 2'd1;
          w_tmr_clear     = 1'b1;
          w_state_nxt     = S_GAP;
        end else begin
          w_state_nxt = S_REPORT;
        end
      end
      S_REPORT: begin
        w_done_nxt      = 1'b1;
        w_status_nxt    = r_pend;
        w_retries_nxt   = r_retry_cnt;
        w_retry_cnt_nxt = '0;
        w_req_ready_nxt = 1'b1;
        w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_req_ready     = r_req_ready;
  assign o_xcvr_tx_data  = r_tx_data;
  assign o_xcvr_tx_valid = r_tx_valid;
  assign o_done          = r_done;
  assign o_status        = r_status;
  assign o_retries_used  = r_retries_used;

endmodule

// File: tb/tb_usb_txn_controller.sv
// ---------------------------------------------------------------------------
// tb_usb_txn_controller
// Directed bench for usb_txn_controller with a small transceiver model.
// Inputs are driven and outputs sampled on the falling clock edge; cyc counts
// rising edges so latencies are expressed in clock cycles.
// ---------------------------------------------------------------------------
module tb_usb_txn_controller;
  import usb_pkg::*;

  logic        clk = 1'b0;
  logic        nRST = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [3:0]  i_req_pid = '0;
  logic [15:0] i_req_body = '0;
  logic [7:0]  o_xcvr_tx_data;
  logic        o_xcvr_tx_valid;
  logic        i_xcvr_tx_ack = 1'b0;
  logic        i_xcvr_tx_done = 1'b0;
  logic [7:0]  i_xcvr_rx_data = '0;
  logic        i_xcvr_rx_valid = 1'b0;
  logic        i_xcvr_rx_eop = 1'b0;
  logic        i_xcvr_rx_error = 1'b0;
  logic        o_done;
  logic [2:0]  o_status;
  logic [1:0]  o_retries_used;

  int cyc = 0;
  int doneCount = 0;
  int total = 0;
  int bad = 0;
  int acc, first, txd, r, d, prevTxd, dcSnap;

  usb_txn_controller dut (
    .clk             (clk),
    .nRST            (nRST),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_pid       (i_req_pid),
    .i_req_body      (i_req_body),
    .o_xcvr_tx_data  (o_xcvr_tx_data),
    .o_xcvr_tx_valid (o_xcvr_tx_valid),
    .i_xcvr_tx_ack   (i_xcvr_tx_ack),
    .i_xcvr_tx_done  (i_xcvr_tx_done),
    .i_xcvr_rx_data  (i_xcvr_rx_data),
    .i_xcvr_rx_valid (i_xcvr_rx_valid),
    .i_xcvr_rx_eop   (i_xcvr_rx_eop),
    .i_xcvr_rx_error (i_xcvr_rx_error),
    .o_done          (o_done),
    .o_status        (o_status),
    .o_retries_used  (o_retries_used)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_done) doneCount <= doneCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present a request for one cycle, then scramble the request inputs so a
  // controller that re-reads them after accept sends wrong bytes.
  task automatic applyStimulus(input logic [3:0] pid, input logic [15:0] body, output int acceptEdge);
    @(negedge clk);
    checkOutput("ready_before_req", o_req_ready, 1);
    i_req_valid = 1'b1;
    i_req_pid   = pid;
    i_req_body  = body;
    acceptEdge  = cyc + 1;
    @(negedge clk);
    i_req_valid = 1'b0;
    i_req_pid   = ~pid;
    i_req_body  = ~body;
    checkOutput("ready_after_accept", o_req_ready, 0);
  endtask

  task automatic waitTxValid(input string tag, input int budget, output int edgeCyc);
    edgeCyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_xcvr_tx_valid) begin
        edgeCyc = cyc;
        break;
      end
    end
    if (edgeCyc < 0) checkOutput({tag, "_txvalid_timeout"}, 0, 1);
  endtask

  task automatic waitDone(input string tag, input int budget, output int edgeCyc);
    edgeCyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_done) begin
        edgeCyc = cyc;
        break;
      end
    end
    if (edgeCyc < 0) checkOutput({tag, "_done_timeout"}, 0, 1);
  endtask

  // Transceiver side of one packet: check and ack three bytes, check that
  // tx_valid drops, then pulse tx_done.
  task automatic txPacket(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, output int firstEdge, output int doneEdge);
    logic [7:0] exp [3];
    int e;
    exp[0] = b0;
    exp[1] = b1;
    exp[2] = b2;
    firstEdge = -1;
    for (int i = 0; i < 3; i++) begin
      waitTxValid(tag, 2000, e);
      if (i == 0) firstEdge = e;
      checkOutput($sformatf("%s_byte%0d", tag, i), o_xcvr_tx_data, exp[i]);
      i_xcvr_tx_ack = 1'b1;
      @(negedge clk);
      i_xcvr_tx_ack = 1'b0;
    end
    checkOutput({tag, "_txvalid_drop"}, o_xcvr_tx_valid, 0);
    i_xcvr_tx_done = 1'b1;
    doneEdge = cyc + 1;
    @(negedge clk);
    i_xcvr_tx_done = 1'b0;
  endtask

  task automatic rxStrobe(input logic [7:0] data, input logic valid, input logic eop,
                          input logic err, output int edgeCyc);
    i_xcvr_rx_data  = data;
    i_xcvr_rx_valid = valid;
    i_xcvr_rx_eop   = eop;
    i_xcvr_rx_error = err;
    edgeCyc = cyc + 1;
    @(negedge clk);
    i_xcvr_rx_valid = 1'b0;
    i_xcvr_rx_eop   = 1'b0;
    i_xcvr_rx_error = 1'b0;
  endtask

  initial begin
    #1 nRST = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", o_req_ready, 1);
    checkOutput("rst_txvalid", o_xcvr_tx_valid, 0);
    checkOutput("rst_txdata", o_xcvr_tx_data, 8'h00);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_status", o_status, ST_NONE);
    checkOutput("rst_retries", o_retries_used, 0);
    nRST = 1'b1;
    repeat (2) @(negedge clk);

    // Plain IN transaction answered with ACK.
    applyStimulus(4'b1001, 16'h1A2B, acc);
    txPacket("ack", 8'h69, 8'h2B, 8'h1A, first, txd);
    checkOutput("ack_gap", first - acc, 64);
    repeat (3) @(negedge clk);
    rxStrobe(8'hD2, 1'b1, 1'b1, 1'b0, r);
    waitDone("ack", 20, d);
    checkOutput("ack_done_lat", d - r, 1);
    checkOutput("ack_status", o_status, ST_ACK);
    checkOutput("ack_retries", o_retries_used, 0);
    checkOutput("ack_ready", o_req_ready, 1);
    @(negedge clk);
    checkOutput("ack_done_pulse", o_done, 0);
    checkOutput("ack_status_held", o_status, ST_ACK);

    // NAK, NAK, ACK: three identical packets.
    applyStimulus(4'b0011, 16'hBEEF, acc);
    for (int a = 0; a < 3; a++) begin
      txPacket($sformatf("nak%0d", a), 8'hC3, 8'hEF, 8'hBE, first, txd);
      if (a == 0) checkOutput("nak_gap0", first - acc, 64);
      else        checkOutput($sformatf("nak_gap%0d", a), first - r, 65);
      rxStrobe((a < 2) ? 8'h5A : 8'hD2, 1'b1, 1'b1, 1'b0, r);
    end
    waitDone("nak", 20, d);
    checkOutput("nak_done_lat", d - r, 1);
    checkOutput("nak_status", o_status, ST_ACK);
    checkOutput("nak_retries", o_retries_used, 2);

    // Silence after every packet: four attempts, then TIMEOUT.
    applyStimulus(4'b1101, 16'h0080, acc);
    prevTxd = 0;
    for (int a = 0; a < 4; a++) begin
      txPacket($sformatf("to%0d", a), 8'h2D, 8'h80, 8'h00, first, txd);
      if (a > 0) checkOutput($sformatf("to_gap%0d", a), first - prevTxd, 1089);
      prevTxd = txd;
    end
    waitDone("to", 1200, d);
    checkOutput("to_done_lat", d - txd, 1026);
    checkOutput("to_status", o_status, ST_TIMEOUT);
    checkOutput("to_retries", o_retries_used, 3);

    // Bad check nibble, then STALL.
    applyStimulus(4'b0001, 16'hC0DE, acc);
    txPacket("stall0", 8'hE1, 8'hDE, 8'hC0, first, txd);
    rxStrobe(8'hD3, 1'b1, 1'b1, 1'b0, r);
    txPacket("stall1", 8'hE1, 8'hDE, 8'hC0, first, txd);
    checkOutput("stall_gap", first - r, 65);
    rxStrobe(8'h1E, 1'b1, 1'b1, 1'b0, r);
    waitDone("stall", 20, d);
    checkOutput("stall_done_lat", d - r, 1);
    checkOutput("stall_status", o_status, ST_STALL);
    checkOutput("stall_retries", o_retries_used, 1);

    // Error variants on every attempt: two bytes, rx_error, bare eop,
    // and rx_error alongside a valid ACK byte with eop.
    applyStimulus(4'b1011, 16'h0102, acc);
    for (int a = 0; a < 4; a++) begin
      txPacket($sformatf("err%0d", a), 8'h4B, 8'h02, 8'h01, first, txd);
      if (a > 0) checkOutput($sformatf("err_gap%0d", a), first - r, 65);
      case (a)
        0: begin
          rxStrobe(8'hD2, 1'b1, 1'b0, 1'b0, r);
          rxStrobe(8'hD2, 1'b1, 1'b1, 1'b0, r);
        end
        1:       rxStrobe(8'h00, 1'b0, 1'b0, 1'b1, r);
        2:       rxStrobe(8'h00, 1'b0, 1'b1, 1'b0, r);
        default: rxStrobe(8'hD2, 1'b1, 1'b1, 1'b1, r);
      endcase
    end
    waitDone("err", 20, d);
    checkOutput("err_done_lat", d - r, 2);
    checkOutput("err_status", o_status, ST_ERROR);
    checkOutput("err_retries", o_retries_used, 3);

    // ACK arriving exactly on the timeout cycle counts as a response.
    applyStimulus(4'b1001, 16'h3344, acc);
    txPacket("edge", 8'h69, 8'h44, 8'h33, first, txd);
    while (cyc < txd + 1023) @(negedge clk);
    rxStrobe(8'hD2, 1'b1, 1'b1, 1'b0, r);
    waitDone("edge", 20, d);
    checkOutput("edge_done_at", d - txd, 1025);
    checkOutput("edge_status", o_status, ST_ACK);
    checkOutput("edge_retries", o_retries_used, 0);

    // Reset while the first body byte is pending, then a clean request.
    applyStimulus(4'b1001, 16'hAA55, acc);
    waitTxValid("rst_mid", 200, first);
    checkOutput("rst_mid_pid", o_xcvr_tx_data, 8'h69);
    i_xcvr_tx_ack = 1'b1;
    @(negedge clk);
    i_xcvr_tx_ack = 1'b0;
    checkOutput("rst_mid_b0", o_xcvr_tx_data, 8'h55);
    dcSnap = doneCount;
    nRST = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_txvalid", o_xcvr_tx_valid, 0);
    checkOutput("rst_mid_ready", o_req_ready, 1);
    checkOutput("rst_mid_status", o_status, ST_NONE);
    nRST = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("rst_mid_no_done", doneCount - dcSnap, 0);
    checkOutput("rst_mid_idle_tx", o_xcvr_tx_valid, 0);
    applyStimulus(4'b0001, 16'h1234, acc);
    txPacket("post", 8'hE1, 8'h34, 8'h12, first, txd);
    checkOutput("post_gap", first - acc, 64);
    rxStrobe(8'hD2, 1'b1, 1'b1, 1'b0, r);
    waitDone("post", 20, d);
    checkOutput("post_status", o_status, ST_ACK);
    checkOutput("post_retries", o_retries_used, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=expired expected=finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
